// File: rtl/uart_ctl_gen2.sv
// uart_ctl_gen2: parametrised UART transceiver for the SPI-to-UART bridge.
// TX pulls words from the TX FIFO and serialises them; RX oversamples the
// line, majority-votes each bit and pushes completed words to the RX FIFO.
// Parity (none/even/odd) and stop count are latched per frame; error
// status bits are sticky until err_clr, and a set always beats a clear.
module uart_ctl_gen2 #(
    parameter int DATA_W = 16,
    parameter int DIV_W  = 16,
    parameter int OVS    = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              tx,
    input  logic              rx,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_empty,
    output logic              tx_fifo_en,
    output logic [DATA_W-1:0] rx_data,
    input  logic              rx_full,
    output logic              rx_fifo_en,
    input  logic [DIV_W-1:0]  baud_divisor,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    input  logic              err_clr,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun_err,
    output logic              break_det,
    output logic              tx_busy,
    output logic              rx_busy
);

    localparam int OVS_W = $clog2(OVS);
    localparam int BIT_W = 5;
    localparam logic [OVS_W-1:0] CNT_LAST = OVS_W'(OVS - 1);
    localparam logic [OVS_W-1:0] CNT_MID  = OVS_W'(OVS / 2);
    localparam logic [OVS_W-1:0] CNT_MIDM = OVS_W'(OVS / 2 - 1);
    localparam logic [OVS_W-1:0] CNT_MIDP = OVS_W'(OVS / 2 + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    // Parity bit that completes d to an even (odd=0) or odd (odd=1) count of ones.
    function automatic logic parity_of(input logic [DATA_W-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // Mode 11 is treated the same as no parity.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == 2'b01) || (mode == 2'b10);
    endfunction

    // Two-out-of-three vote across the centre samples of a bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_FETCH, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    tx_state_t         tx_state_r;
    logic              tx_r;
    logic              tx_fifo_en_r;
    logic              tx_busy_r;
    logic              tx_fetch_ph_r;
    logic [DATA_W-1:0] tx_shift_r;
    logic              tx_par_r;
    logic [1:0]        tx_pmode_r;
    logic              tx_stop2_r;
    logic              tx_stop_second_r;
    logic [DIV_W-1:0]  tx_div_r;
    logic [DIV_W-1:0]  tx_pre_r;
    logic [OVS_W-1:0]  tx_cnt_r;
    logic [BIT_W-1:0]  tx_bit_r;
    logic              tx_tick_s;
    logic              tx_bit_end_s;

    assign tx_tick_s    = (tx_pre_r == {DIV_W{1'b0}});
    assign tx_bit_end_s = tx_tick_s && (tx_cnt_r == CNT_LAST);

    // TX FSM: FIFO fetch (strobe, then one wait cycle for read data), then
    // start/data/parity/stop shifting with its own per-frame prescaler.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r       <= TX_IDLE;
            tx_r             <= 1'b1;
            tx_fifo_en_r     <= 1'b0;
            tx_busy_r        <= 1'b0;
            tx_fetch_ph_r    <= 1'b0;
            tx_shift_r       <= {DATA_W{1'b0}};
            tx_par_r         <= 1'b0;
            tx_pmode_r       <= 2'b00;
            tx_stop2_r       <= 1'b0;
            tx_stop_second_r <= 1'b0;
            tx_div_r         <= {DIV_W{1'b0}};
            tx_pre_r         <= {DIV_W{1'b0}};
            tx_cnt_r         <= {OVS_W{1'b0}};
            tx_bit_r         <= {BIT_W{1'b0}};
        end else begin
            tx_fifo_en_r <= 1'b0;
            if (tx_state_r inside {TX_START, TX_DATA, TX_PARITY, TX_STOP}) begin
                if (tx_tick_s) begin
                    tx_pre_r <= tx_div_r;
                    tx_cnt_r <= (tx_cnt_r == CNT_LAST) ? {OVS_W{1'b0}} : tx_cnt_r + OVS_W'(1);
                end else begin
                    tx_pre_r <= tx_pre_r - DIV_W'(1);
                end
            end
            case (tx_state_r)
                TX_IDLE: begin
                    if (!tx_empty) begin
                        tx_fifo_en_r  <= 1'b1;
                        tx_fetch_ph_r <= 1'b0;
                        tx_busy_r     <= 1'b1;
                        tx_state_r    <= TX_FETCH;
                    end
                end
                TX_FETCH: begin
                    if (!tx_fetch_ph_r) begin
                        tx_fetch_ph_r <= 1'b1;
                    end else begin
                        tx_shift_r       <= tx_data;
                        tx_par_r         <= parity_of(tx_data, parity_mode == 2'b10);
                        tx_pmode_r       <= parity_mode;
                        tx_stop2_r       <= stop2;
                        tx_stop_second_r <= 1'b0;
                        tx_div_r         <= baud_divisor;
                        tx_pre_r         <= baud_divisor;
                        tx_cnt_r         <= {OVS_W{1'b0}};
                        tx_bit_r         <= {BIT_W{1'b0}};
                        tx_r             <= 1'b0;
                        tx_state_r       <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_bit_end_s) begin
                        tx_r       <= tx_shift_r[0];
                        tx_state_r <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end_s) begin
                        if (tx_bit_r == BIT_LAST) begin
                            if (parity_enabled(tx_pmode_r)) begin
                                tx_r       <= tx_par_r;
                                tx_state_r <= TX_PARITY;
                            end else begin
                                tx_r       <= 1'b1;
                                tx_state_r <= TX_STOP;
                            end
                        end else begin
                            tx_r       <= tx_shift_r[1];
                            tx_shift_r <= tx_shift_r >> 1;
                            tx_bit_r   <= tx_bit_r + BIT_W'(1);
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_bit_end_s) begin
                        tx_r       <= 1'b1;
                        tx_state_r <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end_s) begin
                        if (tx_stop2_r && !tx_stop_second_r) begin
                            tx_stop_second_r <= 1'b1;
                        end else if (!tx_empty) begin
                            tx_fifo_en_r  <= 1'b1;
                            tx_fetch_ph_r <= 1'b0;
                            tx_state_r    <= TX_FETCH;
                        end else begin
                            tx_busy_r  <= 1'b0;
                            tx_state_r <= TX_IDLE;
                        end
                    end
                end
                default: begin
                    tx_r       <= 1'b1;
                    tx_busy_r  <= 1'b0;
                    tx_state_r <= TX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    logic              rx_meta_r;
    logic              rx_sync_r;
    logic              rx_prev_r;
    logic              rx_fall_s;

    // Two-flop synchroniser plus delayed copy for start-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    assign rx_fall_s = rx_prev_r & ~rx_sync_r;

    rx_state_t         rx_state_r;
    logic              rx_busy_r;
    logic              rx_fifo_en_r;
    logic [DATA_W-1:0] rx_data_r;
    logic [DATA_W-1:0] rx_shift_r;
    logic              rx_par_bit_r;
    logic [1:0]        rx_pmode_r;
    logic [DIV_W-1:0]  rx_div_r;
    logic [DIV_W-1:0]  rx_pre_r;
    logic [OVS_W-1:0]  rx_cnt_r;
    logic [BIT_W-1:0]  rx_bit_r;
    logic              rx_s0_r;
    logic              rx_s1_r;
    logic              parity_err_r;
    logic              frame_err_r;
    logic              overrun_err_r;
    logic              break_det_r;
    logic              rx_tick_s;
    logic              rx_bit_end_s;
    logic              rx_vote_tick_s;
    logic              rx_vote_s;

    assign rx_tick_s      = (rx_pre_r == {DIV_W{1'b0}});
    assign rx_bit_end_s   = rx_tick_s && (rx_cnt_r == CNT_LAST);
    assign rx_vote_tick_s = rx_tick_s && (rx_cnt_r == CNT_MIDP);
    assign rx_vote_s      = maj3(rx_s0_r, rx_s1_r, rx_sync_r);

    // RX FSM: start validation, voted bit capture, stop-sample decision and
    // sticky status (clear is applied first so a same-cycle set wins).
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_r    <= RX_IDLE;
            rx_busy_r     <= 1'b0;
            rx_fifo_en_r  <= 1'b0;
            rx_data_r     <= {DATA_W{1'b0}};
            rx_shift_r    <= {DATA_W{1'b0}};
            rx_par_bit_r  <= 1'b0;
            rx_pmode_r    <= 2'b00;
            rx_div_r      <= {DIV_W{1'b0}};
            rx_pre_r      <= {DIV_W{1'b0}};
            rx_cnt_r      <= {OVS_W{1'b0}};
            rx_bit_r      <= {BIT_W{1'b0}};
            rx_s0_r       <= 1'b1;
            rx_s1_r       <= 1'b1;
            parity_err_r  <= 1'b0;
            frame_err_r   <= 1'b0;
            overrun_err_r <= 1'b0;
            break_det_r   <= 1'b0;
        end else begin
            rx_fifo_en_r <= 1'b0;
            if (err_clr) begin
                parity_err_r  <= 1'b0;
                frame_err_r   <= 1'b0;
                overrun_err_r <= 1'b0;
                break_det_r   <= 1'b0;
            end
            if (rx_state_r != RX_IDLE) begin
                if (rx_tick_s) begin
                    rx_pre_r <= rx_div_r;
                    rx_cnt_r <= (rx_cnt_r == CNT_LAST) ? {OVS_W{1'b0}} : rx_cnt_r + OVS_W'(1);
                    if (rx_cnt_r == CNT_MIDM) begin
                        rx_s0_r <= rx_sync_r;
                    end
                    if (rx_cnt_r == CNT_MID) begin
                        rx_s1_r <= rx_sync_r;
                    end
                end else begin
                    rx_pre_r <= rx_pre_r - DIV_W'(1);
                end
            end
            case (rx_state_r)
                RX_IDLE: begin
                    if (rx_fall_s) begin
                        rx_div_r   <= baud_divisor;
                        rx_pre_r   <= baud_divisor;
                        rx_cnt_r   <= {OVS_W{1'b0}};
                        rx_bit_r   <= {BIT_W{1'b0}};
                        rx_pmode_r <= parity_mode;
                        rx_busy_r  <= 1'b1;
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_tick_s && (rx_cnt_r == CNT_MID) && rx_sync_r) begin
                        rx_busy_r  <= 1'b0;
                        rx_state_r <= RX_IDLE;
                    end else if (rx_bit_end_s) begin
                        rx_state_r <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_vote_tick_s) begin
                        rx_shift_r <= {rx_vote_s, rx_shift_r[DATA_W-1:1]};
                    end
                    if (rx_bit_end_s) begin
                        if (rx_bit_r == BIT_LAST) begin
                            rx_state_r <= parity_enabled(rx_pmode_r) ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bit_r <= rx_bit_r + BIT_W'(1);
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_vote_tick_s) begin
                        rx_par_bit_r <= rx_vote_s;
                    end
                    if (rx_bit_end_s) begin
                        rx_state_r <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_vote_tick_s) begin
                        if (!rx_vote_s && (rx_shift_r == {DATA_W{1'b0}}) &&
                            !(parity_enabled(rx_pmode_r) && rx_par_bit_r)) begin
                            break_det_r <= 1'b1;
                            frame_err_r <= 1'b1;
                        end else if (!rx_vote_s) begin
                            frame_err_r <= 1'b1;
                        end else if (rx_full) begin
                            overrun_err_r <= 1'b1;
                        end else begin
                            rx_fifo_en_r <= 1'b1;
                            rx_data_r    <= rx_shift_r;
                            if (parity_enabled(rx_pmode_r) &&
                                (rx_par_bit_r != parity_of(rx_shift_r, rx_pmode_r == 2'b10))) begin
                                parity_err_r <= 1'b1;
                            end
                        end
                        rx_busy_r  <= 1'b0;
                        rx_state_r <= RX_IDLE;
                    end
                end
                default: begin
                    rx_busy_r  <= 1'b0;
                    rx_state_r <= RX_IDLE;
                end
            endcase
        end
    end

    assign tx          = tx_r;
    assign tx_fifo_en  = tx_fifo_en_r;
    assign tx_busy     = tx_busy_r;
    assign rx_fifo_en  = rx_fifo_en_r;
    assign rx_data     = rx_data_r;
    assign rx_busy     = rx_busy_r;
    assign parity_err  = parity_err_r;
    assign frame_err   = frame_err_r;
    assign overrun_err = overrun_err_r;
    assign break_det   = break_det_r;

endmodule

// File: tb/tb_uart_ctl_gen2.sv
// Directed testbench for uart_ctl_gen2 (DATA_W=8, OVS=16, divisor 0:
// one bit = 16 clocks). A small TX FIFO model feeds the transmitter and a
// monitor collects every word written toward the RX FIFO.
module tb_uart_ctl_gen2;

    localparam int DATA_W = 8;
    localparam int DIV_W  = 16;
    localparam int OVS    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              tx;
    logic              rx_wire;
    logic              rx_drv;
    logic              loop_en;
    logic [DATA_W-1:0] tx_data = 8'h00;
    logic              tx_empty = 1'b1;
    logic              tx_fifo_en;
    logic [DATA_W-1:0] rx_data;
    logic              rx_full;
    logic              rx_fifo_en;
    logic [DIV_W-1:0]  baud_divisor;
    logic [1:0]        parity_mode;
    logic              stop2;
    logic              err_clr;
    logic              parity_err;
    logic              frame_err;
    logic              overrun_err;
    logic              break_det;
    logic              tx_busy;
    logic              rx_busy;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    int         tx_pulses = 0;
    int         errors = 0;
    int         checks = 0;

    assign rx_wire = loop_en ? tx : rx_drv;

    uart_ctl_gen2 #(.DATA_W(DATA_W), .DIV_W(DIV_W), .OVS(OVS)) dut (
        .clk(clk), .rst(rst), .tx(tx), .rx(rx_wire),
        .tx_data(tx_data), .tx_empty(tx_empty), .tx_fifo_en(tx_fifo_en),
        .rx_data(rx_data), .rx_full(rx_full), .rx_fifo_en(rx_fifo_en),
        .baud_divisor(baud_divisor), .parity_mode(parity_mode), .stop2(stop2),
        .err_clr(err_clr), .parity_err(parity_err), .frame_err(frame_err),
        .overrun_err(overrun_err), .break_det(break_det),
        .tx_busy(tx_busy), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    // TX FIFO model: a read strobe seen at an edge presents the next word just after it.
    always begin : tx_fifo_model
        logic pop;
        @(posedge clk);
        pop = tx_fifo_en;
        #1;
        if (pop && (txq.size() > 0)) begin
            tx_data = txq.pop_front();
        end
        tx_empty = (txq.size() == 0);
    end

    // Monitor: record RX FIFO writes and count TX FIFO read strobes.
    always @(posedge clk) begin
        if (rx_fifo_en) begin
            rxq.push_back(rx_data);
        end
        if (tx_fifo_en) begin
            tx_pulses++;
        end
    end

    // Watchdog in case a wait is ever left unbounded.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tx_low(input int limit, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; (i < limit) && !ok; i++) begin
            @(posedge clk); #1;
            if (tx === 1'b0) begin
                ok = 1'b1;
            end
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    // Drive one rx frame at 16 clocks per bit; err_clr is high only for clock clr_c.
    task automatic send_frame(input logic [7:0] d, input bit pen, input logic pb,
                              input logic sb, input int clr_c);
        logic [11:0] fb;
        int          nb;
        fb = 12'h000;
        for (int i = 0; i < 8; i++) begin
            fb[1+i] = d[i];
        end
        nb = 9;
        if (pen) begin
            fb[nb] = pb;
            nb++;
        end
        fb[nb] = sb;
        nb++;
        for (int c = 0; c < nb * 16; c++) begin
            rx_drv  = fb[c/16];
            err_clr = (c == clr_c);
            @(posedge clk); #1;
        end
        rx_drv  = 1'b1;
        err_clr = 1'b0;
        tick(4);
    endtask

    initial begin
        logic [9:0] fr;
        int         base;
        int         pulses_before;
        bit         ok;

        rst = 1'b1; rx_drv = 1'b1; loop_en = 1'b0; rx_full = 1'b0;
        baud_divisor = 16'd0; parity_mode = 2'b00; stop2 = 1'b0; err_clr = 1'b0;
        tick(3);

        // Reset state
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_tx_fifo_en", {31'd0, tx_fifo_en}, 32'd0);
        check("rst_rx_fifo_en", {31'd0, rx_fifo_en}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_status", {28'd0, parity_err, frame_err, overrun_err, break_det}, 32'd0);
        check("rst_busy", {30'd0, tx_busy, rx_busy}, 32'd0);
        rst = 1'b0;
        tick(2);

        // 1: single 0xA5 frame, no parity, one stop bit
        txq.push_back(8'hA5);
        wait_tx_low(20, "t1_start");
        fr = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 160; i++) begin
            check("t1_tx_bit", {31'd0, tx}, {31'd0, fr[i/16]});
            check("t1_tx_busy", {31'd0, tx_busy}, 32'd1);
            tick(1);
        end
        check("t1_tx_idle", {31'd0, tx}, 32'd1);
        check("t1_busy_end", {31'd0, tx_busy}, 32'd0);
        check("t1_pulses", tx_pulses, 32'd1);

        // 2: loopback, even parity, 0x37 then 0x00 back to back
        parity_mode = 2'b01;
        loop_en = 1'b1;
        base = rxq.size();
        txq.push_back(8'h37);
        txq.push_back(8'h00);
        wait_tx_low(20, "t2_start0");
        tick(152);
        check("t2_parity0", {31'd0, tx}, 32'd1);
        wait_tx_low(60, "t2_start1");
        tick(152);
        check("t2_parity1", {31'd0, tx}, 32'd0);
        ok = 1'b0;
        for (int i = 0; (i < 300) && !ok; i++) begin
            tick(1);
            ok = (rxq.size() >= base + 2);
        end
        check("t2_rx_count", rxq.size(), base + 2);
        if (ok) begin
            check("t2_word0", {24'd0, rxq[base]}, 32'h37);
            check("t2_word1", {24'd0, rxq[base+1]}, 32'h00);
        end
        check("t2_status", {28'd0, parity_err, frame_err, overrun_err, break_det}, 32'd0);
        check("t2_pulses", tx_pulses, 32'd3);
        ok = 1'b0;
        for (int i = 0; (i < 100) && !ok; i++) begin
            tick(1);
            ok = (tx_busy === 1'b0);
        end
        check("t2_tx_done", {31'd0, ok}, 32'd1);
        loop_en = 1'b0;
        tick(4);

        // 3: parity error sticky, clear, and set-wins-over-clear
        base = rxq.size();
        send_frame(8'h37, 1'b1, 1'b0, 1'b1, -1);
        check("t3_written", rxq.size(), base + 1);
        if (rxq.size() > base) begin
            check("t3_word", {24'd0, rxq[base]}, 32'h37);
        end
        check("t3_parity_err", {31'd0, parity_err}, 32'd1);
        check("t3_frame_err", {31'd0, frame_err}, 32'd0);
        pulse_clr();
        check("t3_cleared", {31'd0, parity_err}, 32'd0);
        send_frame(8'h37, 1'b1, 1'b0, 1'b1, 172);
        check("t3_set_wins", {31'd0, parity_err}, 32'd1);
        check("t3_written2", rxq.size(), base + 2);

        // 4: framing error, then break
        parity_mode = 2'b00;
        pulse_clr();
        base = rxq.size();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, -1);
        check("t4_frame_err", {31'd0, frame_err}, 32'd1);
        check("t4_no_break", {31'd0, break_det}, 32'd0);
        check("t4_no_write", rxq.size(), base);
        pulse_clr();
        check("t4_cleared", {31'd0, frame_err}, 32'd0);
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, -1);
        check("t4_break", {31'd0, break_det}, 32'd1);
        check("t4_break_frame", {31'd0, frame_err}, 32'd1);
        check("t4_no_write2", rxq.size(), base);

        // 5: overrun drops the word, next frame is written
        pulse_clr();
        rx_full = 1'b1;
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, -1);
        check("t5_overrun", {31'd0, overrun_err}, 32'd1);
        check("t5_no_write", rxq.size(), base);
        rx_full = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1);
        check("t5_written", rxq.size(), base + 1);
        if (rxq.size() > base) begin
            check("t5_word", {24'd0, rxq[base]}, 32'h3C);
        end
        check("t5_overrun_sticky", {31'd0, overrun_err}, 32'd1);
        check("t5_frame_ok", {31'd0, frame_err}, 32'd0);

        // 6a: three-clock low glitch is a false start
        base = rxq.size();
        rx_drv = 1'b0;
        tick(3);
        rx_drv = 1'b1;
        tick(2);
        check("t6_rx_busy_on", {31'd0, rx_busy}, 32'd1);
        tick(15);
        check("t6_rx_busy_off", {31'd0, rx_busy}, 32'd0);
        check("t6_no_write", rxq.size(), base);

        // 6b: reset in the middle of a TX frame
        txq.push_back(8'hC3);
        txq.push_back(8'h5A);
        wait_tx_low(20, "t6_start");
        tick(40);
        check("t6_mid_busy", {31'd0, tx_busy}, 32'd1);
        pulses_before = tx_pulses;
        rst = 1'b1;
        tick(1);
        check("t6_rst_tx", {31'd0, tx}, 32'd1);
        check("t6_rst_busy", {31'd0, tx_busy}, 32'd0);
        check("t6_rst_overrun", {31'd0, overrun_err}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("t6_rst_no_fetch", {31'd0, tx_fifo_en}, 32'd0);
            tick(1);
        end
        check("t6_rst_pulses", tx_pulses, pulses_before);
        rst = 1'b0;
        tick(1);
        check("t6_resume_fetch", {31'd0, tx_fifo_en}, 32'd1);
        tick(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
